// File: rtl/aardvark_ctrl_seq.sv
// Multi-cycle control sequencer for the Aardvark 8-bit datapath.
// Steps one instruction at a time through DECODE / EXEC / MEM / WB and counts retirements.
module aardvark_ctrl_seq (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] instr,
  input  logic       instr_valid,
  output logic       instr_ready,
  input  logic       mem_ack,
  output logic [1:0] reg_a,
  output logic [1:0] reg_b,
  output logic       wb_sel,
  output logic [2:0] alu_op,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_we,
  output logic       done,
  output logic       pc_inc,
  output logic       illegal,
  output logic       halted,
  output logic [7:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  state_t     state;
  logic [7:0] ir;
  logic       done_r;
  logic [3:0] new_op;
  logic [3:0] ir_op;

  assign new_op = instr[7:4];
  assign ir_op  = ir[7:4];

  assign instr_ready = (state == S_IDLE);
  assign halted      = (state == S_HALT);
  assign reg_a       = ir[3:2];
  assign reg_b       = ir[1:0];

  // A store retires in the MEM cycle that sees the ack, so that done is not registered.
  assign done   = done_r | ((state == S_MEM) && mem_wr && mem_ack);
  assign pc_inc = done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      ir      <= '0;
      retired <= '0;
      done_r  <= 1'b0;
      illegal <= 1'b0;
      reg_we  <= 1'b0;
      wb_sel  <= 1'b0;
      alu_op  <= '0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      illegal <= 1'b0;
      reg_we  <= 1'b0;
      wb_sel  <= 1'b0;
      alu_op  <= '0;
      mem_rd  <= 1'b0;
      mem_wr  <= 1'b0;
      retired <= retired + {7'd0, done};

      case (state)
        S_IDLE: begin
          if (instr_valid) begin
            ir      <= instr;
            state   <= S_DECODE;
            // Strobes for the DECODE cycle are decided from the incoming word.
            done_r  <= (new_op == 4'd0) || (new_op >= 4'd7);
            illegal <= new_op[3];
          end
        end
        S_DECODE: begin
          if (ir_op >= 4'd1 && ir_op <= 4'd4) begin
            state  <= S_EXEC;
            alu_op <= ir_op[2:0];
          end else if (ir_op == 4'd5) begin
            state  <= S_MEM;
            mem_rd <= 1'b1;
          end else if (ir_op == 4'd6) begin
            state  <= S_MEM;
            mem_wr <= 1'b1;
          end else if (ir_op == 4'd7) begin
            state  <= S_HALT;
          end else begin
            state  <= S_IDLE;
          end
        end
        S_EXEC: begin
          state  <= S_WB;
          alu_op <= alu_op;
          reg_we <= 1'b1;
          wb_sel <= 1'b1;
          done_r <= 1'b1;
        end
        S_MEM: begin
          if (mem_ack) begin
            if (mem_rd) begin
              state  <= S_WB;
              reg_we <= 1'b1;
              done_r <= 1'b1;
            end else begin
              state  <= S_IDLE;
            end
          end else begin
            mem_rd <= mem_rd;
            mem_wr <= mem_wr;
          end
        end
        S_WB: begin
          state <= S_IDLE;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_aardvark_ctrl_seq.sv
// Self-checking bench for aardvark_ctrl_seq: directed scenarios plus a random instruction stream
// compared cycle by cycle against per-instruction expected output sequences.
module tb_aardvark_ctrl_seq;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] instr;
  logic       instr_valid;
  logic       instr_ready;
  logic       mem_ack;
  logic [1:0] reg_a;
  logic [1:0] reg_b;
  logic       wb_sel;
  logic [2:0] alu_op;
  logic       mem_rd;
  logic       mem_wr;
  logic       reg_we;
  logic       done;
  logic       pc_inc;
  logic       illegal;
  logic       halted;
  logic [7:0] retired;

  int         n_checks = 0;
  int         n_errs   = 0;
  int unsigned exp_ret = 0;
  logic [7:0] cur_ir   = '0;

  always #5 clk = ~clk;

  aardvark_ctrl_seq dut (
    .clk         (clk),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .mem_ack     (mem_ack),
    .reg_a       (reg_a),
    .reg_b       (reg_b),
    .wb_sel      (wb_sel),
    .alu_op      (alu_op),
    .mem_rd      (mem_rd),
    .mem_wr      (mem_wr),
    .reg_we      (reg_we),
    .done        (done),
    .pc_inc      (pc_inc),
    .illegal     (illegal),
    .halted      (halted),
    .retired     (retired)
  );

  logic [15:0] outs;
  assign outs = {instr_ready, reg_a, reg_b, wb_sel, alu_op, mem_rd, mem_wr,
                 reg_we, done, pc_inc, illegal, halted};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Expected output word; pc_inc always mirrors done.
  function automatic logic [15:0] vec(input logic rdy, input logic [1:0] a, input logic [1:0] b,
                                      input logic ws, input logic [2:0] op, input logic rd,
                                      input logic wr, input logic we, input logic dn,
                                      input logic il, input logic hl);
    return {rdy, a, b, ws, op, rd, wr, we, dn, dn, il, hl};
  endfunction

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  function automatic logic [15:0] idle_vec();
    return vec(1'b1, cur_ir[3:2], cur_ir[1:0], 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endfunction

  // One clock: drive inputs, compare before the edge, then advance the retire model.
  task automatic cycle(input string tag, input logic rst, input logic v, input logic [7:0] ins,
                       input logic ack, input logic [15:0] ev);
    reset       = rst;
    instr_valid = v;
    instr       = ins;
    mem_ack     = ack;
    @(negedge clk);
    check(tag, {16'd0, outs}, {16'd0, ev});
    check({tag, "/retired"}, {24'd0, retired}, {24'd0, exp_ret[7:0]});
    @(posedge clk);
    #1;
    if (rst) exp_ret = 0;
    else if (ev[3]) exp_ret = (exp_ret + 1) % 256;
  endtask

  task automatic run_instr(input logic [7:0] ins, input int unsigned dly, input int unsigned gap);
    logic [3:0] op;
    logic [1:0] a;
    logic [1:0] b;
    logic [15:0] quiet;
    op = ins[7:4];
    a  = ins[3:2];
    b  = ins[1:0];
    for (int unsigned i = 0; i < gap; i++)
      cycle("idle", 1'b0, 1'b0, 8'($urandom), rnd(), idle_vec());
    cycle("accept", 1'b0, 1'b1, ins, rnd(), idle_vec());
    cur_ir = ins;
    quiet = vec(1'b0, a, b, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    if (op == 4'd0) begin
      cycle("nop_dec", 1'b0, rnd(), 8'($urandom), rnd(),
            vec(1'b0, a, b, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    end else if (op <= 4'd4) begin
      cycle("alu_dec", 1'b0, rnd(), 8'($urandom), rnd(), quiet);
      cycle("alu_exec", 1'b0, rnd(), 8'($urandom), rnd(),
            vec(1'b0, a, b, 1'b0, op[2:0], 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      cycle("alu_wb", 1'b0, rnd(), 8'($urandom), rnd(),
            vec(1'b0, a, b, 1'b1, op[2:0], 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    end else if (op == 4'd5) begin
      cycle("lw_dec", 1'b0, rnd(), 8'($urandom), rnd(), quiet);
      for (int unsigned i = 0; i < dly; i++)
        cycle("lw_wait", 1'b0, rnd(), 8'($urandom), 1'b0,
              vec(1'b0, a, b, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      cycle("lw_ack", 1'b0, rnd(), 8'($urandom), 1'b1,
            vec(1'b0, a, b, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
      cycle("lw_wb", 1'b0, rnd(), 8'($urandom), rnd(),
            vec(1'b0, a, b, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0));
    end else if (op == 4'd6) begin
      cycle("sw_dec", 1'b0, rnd(), 8'($urandom), rnd(), quiet);
      for (int unsigned i = 0; i < dly; i++)
        cycle("sw_wait", 1'b0, rnd(), 8'($urandom), 1'b0,
              vec(1'b0, a, b, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
      cycle("sw_ack", 1'b0, rnd(), 8'($urandom), 1'b1,
            vec(1'b0, a, b, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0));
    end else if (op == 4'd7) begin
      cycle("halt_dec", 1'b0, rnd(), 8'($urandom), rnd(),
            vec(1'b0, a, b, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0));
    end else begin
      cycle("ill_dec", 1'b0, rnd(), 8'($urandom), rnd(),
            vec(1'b0, a, b, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0));
    end
  endtask

  initial begin
    logic [3:0] op;
    int unsigned r;
    reset       = 1'b1;
    instr_valid = 1'b0;
    instr       = '0;
    mem_ack     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_ret = 0;
    cur_ir  = '0;
    cycle("reset_state", 1'b0, 1'b0, 8'h00, 1'b0, idle_vec());

    run_instr(8'h16, 0, 0);
    run_instr(8'h5B, 3, 1);
    run_instr(8'h64, 0, 0);
    run_instr(8'hA0, 0, 2);

    // Reset while an LW waits for its ack: request dropped, counter cleared.
    run_instr(8'h00, 0, 0);
    cycle("rst_acc", 1'b0, 1'b1, 8'h5B, 1'b0, idle_vec());
    cur_ir = 8'h5B;
    cycle("rst_dec", 1'b0, 1'b0, 8'h00, 1'b0,
          vec(1'b0, 2'd2, 2'd3, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cycle("rst_mem", 1'b0, 1'b0, 8'h00, 1'b0,
          vec(1'b0, 2'd2, 2'd3, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cycle("rst_hit", 1'b1, 1'b0, 8'h00, 1'b1,
          vec(1'b0, 2'd2, 2'd3, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
    cur_ir = '0;
    for (int i = 0; i < 3; i++)
      cycle("rst_after", 1'b0, 1'b0, 8'h00, 1'b1, idle_vec());

    // 256 back-to-back NOPs: two cycles each, counter wraps.
    for (int i = 0; i < 256; i++)
      run_instr({4'h0, 4'($urandom)}, 0, 0);
    cycle("wrap_idle", 1'b0, 1'b0, 8'h00, 1'b0, idle_vec());

    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 9);
      op = (r <= 6) ? 4'(r) : 4'(4'd8 + 4'($urandom_range(0, 7)));
      run_instr({op, 4'($urandom)}, $urandom_range(0, 3), $urandom_range(0, 2));
    end

    run_instr(8'h70, 0, 1);
    for (int i = 0; i < 8; i++)
      cycle("halted", 1'b0, 1'b1, 8'h16, rnd(),
            vec(1'b0, 2'd0, 2'd0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_errs);
    $finish;
  end

endmodule
